contador_mod_n_updown: RTL and testbench
========================================

Name: contador_mod_n_updown

Overview:
- Parametrised modulo-N up/down counter. Successor to the fixed 2-bit mod-4 step counter.
- Used as the nano processor's sequencer or phase counter and as a general event/loop counter.
- Adds the following over the fixed counter:
  - synchronous clear and load
  - count enable and direction
  - wrap or saturate mode
  - terminal-count output for cascading
  - registered wrap event flag

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 10, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH. Elaboration fails with $error outside this range.
- RESET_VAL, 0, value of cnt after rst. Must be < MODULUS, otherwise elaboration error.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low. Clock is clk.
- en  input  1  count enable.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load.
- up  input  1  direction: 1 counts up, 0 counts down.
- sat  input  1  mode: 1 saturates at the terminal value, 0 wraps.
- cnt  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational: en & (up ? cnt==MODULUS-1 : cnt==0).
- wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap occurred.
- load_err  output  1  registered one-cycle pulse, high in the cycle after an out-of-range load.

Behaviour:
- Reset:
  - rst=0 forces cnt=RESET_VAL, wrap=0, load_err=0 immediately, independent of clk.
  - Reset may assert mid-count; the count is abandoned.
  - Release is synchronous to the design; the first count happens at the first rising edge with rst=1.
- Priority at each rising edge: clr > load > en. Inputs not selected are ignored.
- clr=1: cnt<=0, wrap<=0, load_err<=0.
- load=1 (clr=0):
  - load_val < MODULUS: cnt<=load_val, load_err<=0.
  - load_val >= MODULUS: cnt<=MODULUS-1, load_err<=1.
  - wrap<=0 in both cases.
- en=1, up=1:
  - cnt < MODULUS-1: cnt<=cnt+1.
  - cnt == MODULUS-1 and sat=0: cnt<=0, wrap<=1.
  - cnt == MODULUS-1 and sat=1: cnt holds, wrap<=0.
- en=1, up=0:
  - cnt > 0: cnt<=cnt-1.
  - cnt == 0 and sat=0: cnt<=MODULUS-1, wrap<=1.
  - cnt == 0 and sat=1: cnt holds, wrap<=0.
- en=0 with no clr or load: cnt holds, wrap<=0, load_err<=0.
- Latency: cnt updates one cycle after the qualifying edge. tc is zero-latency. wrap and load_err appear one cycle after the event.
- Direction or mode change takes effect at the same edge it is sampled. A reversal at the terminal value uses the new direction (e.g. cnt=MODULUS-1, up=0 gives MODULUS-2; no wrap).
- All arithmetic is WIDTH bits wide; intermediate results never exceed MODULUS-1. When MODULUS == 2**WIDTH, wrap is the natural overflow and behaviour is identical.
- tc is intended for cascading: the next stage's en is driven from this stage's tc.

Optional Feature:
- Macro CONTADOR_CAPTURE_EN.
- When defined:
  - Adds input cap (1 bit) and output cap_val (WIDTH bits, registered).
  - On a rising edge with cap=1, cap_val<=cnt (the pre-update value of that edge).
  - rst clears cap_val to 0. clr does not affect cap_val.
- When undefined: the cap and cap_val ports and their logic are absent, and all other behaviour is unchanged.

Test Plan (WIDTH=4, MODULUS=10, RESET_VAL=0 unless stated):
- Up-count wrap: release rst, en=1, up=1, sat=0 for 12 clocks -> cnt runs 1..9, 0, 1, 2. wrap=1 exactly one cycle after the 9->0 edge. tc=1 while cnt=9.
- Down-count and saturate: load 3, then en=1, up=0, sat=1 for 6 clocks -> cnt runs 2, 1, 0, 0, 0, 0. wrap stays 0. tc=1 while cnt=0.
- Priority: clr=1, load=1, load_val=7, en=1 in the same cycle with cnt=5 -> cnt=0. The next cycle with clr=0, load=1 -> cnt=7.
- Out-of-range load: load_val=12 -> cnt=9, load_err=1 for one cycle. Then load_val=4 -> cnt=4, load_err=0.
- Async reset mid-count: with cnt=6, pull rst low between edges -> cnt=0 immediately, before the next clk edge. It stays 0 while rst=0 even with en=1.
- Cascade: two instances with stage-1 en driven from stage-0 tc, both counting up for 100 clocks from 0 -> {stage1,stage0} = 0,0 (decimal 100 mod 100). With CONTADOR_CAPTURE_EN defined, cap pulsed at cnt=6 -> cap_val=6.

Source files
------------

// File: rtl/contador_mod_n_updown_if.sv
// Bus bundle for contador_mod_n_updown. Capture signals are present only when
// CONTADOR_CAPTURE_EN is defined.
interface contador_mod_n_updown_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up;
    logic             sat;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             wrap;
    logic             load_err;
`ifdef CONTADOR_CAPTURE_EN
    logic             cap;
    logic [WIDTH-1:0] cap_val;

    modport master (
        output en, clr, load, load_val, up, sat, cap,
        input  cnt, tc, wrap, load_err, cap_val
    );
    modport slave (
        input  en, clr, load, load_val, up, sat, cap,
        output cnt, tc, wrap, load_err, cap_val
    );
`else
    modport master (
        output en, clr, load, load_val, up, sat,
        input  cnt, tc, wrap, load_err
    );
    modport slave (
        input  en, clr, load, load_val, up, sat,
        output cnt, tc, wrap, load_err
    );
`endif
endinterface

// File: rtl/contador_mod_n_updown.sv
// Modulo-N up/down counter with clear/load, wrap or saturate, terminal count and
// registered wrap/load-error pulses. Optional count capture: CONTADOR_CAPTURE_EN.
module contador_mod_n_updown #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 10,
    parameter int RESET_VAL = 0
) (
    input logic clk,
    input logic rst,
    contador_mod_n_updown_if.slave bus
);
    generate
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
            $error("contador_mod_n_updown: MODULUS %0d outside 2..2**WIDTH", MODULUS);
        end
        if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
            $error("contador_mod_n_updown: RESET_VAL %0d not below MODULUS", RESET_VAL);
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
    // One extra bit so the range test also works when MODULUS == 2**WIDTH
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] cnt_q, cnt_nxt;
    logic             wrap_q, wrap_nxt;
    logic             err_q, err_nxt;
    logic             at_max, at_zero;

    assign at_max  = (cnt_q == MAX_VAL);
    assign at_zero = (cnt_q == '0);

    always_comb begin
        cnt_nxt  = cnt_q;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (bus.clr) begin
            cnt_nxt = '0;
        end else if (bus.load) begin
            if ({1'b0, bus.load_val} >= MOD_EXT) begin
                cnt_nxt = MAX_VAL;
                err_nxt = 1'b1;
            end else begin
                cnt_nxt = bus.load_val;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                if (!at_max) begin
                    cnt_nxt = cnt_q + 1'b1;
                end else if (!bus.sat) begin
                    cnt_nxt  = '0;
                    wrap_nxt = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    cnt_nxt = cnt_q - 1'b1;
                end else if (!bus.sat) begin
                    cnt_nxt  = MAX_VAL;
                    wrap_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= RST_VAL;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            wrap_q <= wrap_nxt;
            err_q  <= err_nxt;
        end
    end

    assign bus.cnt      = cnt_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = err_q;
    // Zero-latency so a following stage can use it directly as its enable
    assign bus.tc       = bus.en & (bus.up ? at_max : at_zero);

`ifdef CONTADOR_CAPTURE_EN
    logic [WIDTH-1:0] cap_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_q <= '0;
        end else if (bus.cap) begin
            cap_q <= cnt_q;
        end
    end

    assign bus.cap_val = cap_q;
`endif
endmodule

// File: tb/tb_contador_mod_n_updown.sv
// Directed bench for contador_mod_n_updown: two cascaded mod-10 stages, stage 1
// enabled by stage 0 terminal count.
module tb_contador_mod_n_updown;
    localparam int W = 4;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    contador_mod_n_updown_if #(.WIDTH(W)) if0 ();
    contador_mod_n_updown_if #(.WIDTH(W)) if1 ();

    contador_mod_n_updown #(.WIDTH(W), .MODULUS(10), .RESET_VAL(0)) u_stage0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    contador_mod_n_updown #(.WIDTH(W), .MODULUS(10), .RESET_VAL(0)) u_stage1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    assign if1.en = if0.tc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst         = 1'b0;
        if0.en      = 1'b0;
        if0.clr     = 1'b0;
        if0.load    = 1'b0;
        if0.load_val = '0;
        if0.up      = 1'b1;
        if0.sat     = 1'b0;
        if1.clr     = 1'b0;
        if1.load    = 1'b0;
        if1.load_val = '0;
        if1.up      = 1'b1;
        if1.sat     = 1'b0;
`ifdef CONTADOR_CAPTURE_EN
        if0.cap     = 1'b0;
        if1.cap     = 1'b0;
`endif
        #3;
        chk("rst_cnt", 32'(if0.cnt), 0);
        chk("rst_wrap", 32'(if0.wrap), 0);
        chk("rst_lerr", 32'(if0.load_err), 0);
`ifdef CONTADOR_CAPTURE_EN
        chk("rst_capval", 32'(if0.cap_val), 0);
`endif

        // Up-count with wrap
        @(negedge clk);
        rst    = 1'b1;
        if0.en = 1'b1;
        #1;
        chk("up_tc0", 32'(if0.tc), 0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("up_cnt", 32'(if0.cnt), 32'(i % 10));
            chk("up_wrap", 32'(if0.wrap), (i == 10) ? 1 : 0);
            chk("up_tc", 32'(if0.tc), ((i % 10) == 9) ? 1 : 0);
        end

        // Load 3, then count down saturating
        if0.en       = 1'b0;
        if0.load     = 1'b1;
        if0.load_val = 4'd3;
        tick();
        chk("ld3_cnt", 32'(if0.cnt), 3);
        chk("ld3_lerr", 32'(if0.load_err), 0);
        if0.load = 1'b0;
        if0.en   = 1'b1;
        if0.up   = 1'b0;
        if0.sat  = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("dn_cnt", 32'(if0.cnt), (i < 3) ? 32'(3 - i) : 0);
            chk("dn_wrap", 32'(if0.wrap), 0);
            chk("dn_tc", 32'(if0.tc), (i >= 3) ? 1 : 0);
        end

        // Down-count wrap from 0 to 9
        if0.sat = 1'b0;
        tick();
        chk("dnwrap_cnt", 32'(if0.cnt), 9);
        chk("dnwrap_wrap", 32'(if0.wrap), 1);

        // Reversal at terminal: cnt=9, up=0 gives 8 without wrap
        tick();
        chk("rev_cnt", 32'(if0.cnt), 8);
        chk("rev_wrap", 32'(if0.wrap), 0);

        // Saturate upward at 9
        if0.up  = 1'b1;
        if0.sat = 1'b1;
        tick();
        chk("satup_a", 32'(if0.cnt), 9);
        tick();
        chk("satup_b", 32'(if0.cnt), 9);
        chk("satup_wrap", 32'(if0.wrap), 0);
        chk("satup_tc", 32'(if0.tc), 1);
        if0.sat = 1'b0;

        // Priority: clr beats load beats en
        if0.en       = 1'b0;
        if0.load     = 1'b1;
        if0.load_val = 4'd5;
        tick();
        chk("pri_pre", 32'(if0.cnt), 5);
        if0.clr      = 1'b1;
        if0.load_val = 4'd7;
        if0.en       = 1'b1;
        tick();
        chk("pri_clr", 32'(if0.cnt), 0);
        if0.clr = 1'b0;
        tick();
        chk("pri_load", 32'(if0.cnt), 7);

        // Out-of-range load clamps to 9 and pulses load_err
        if0.en       = 1'b0;
        if0.load_val = 4'd12;
        tick();
        chk("oor_cnt", 32'(if0.cnt), 9);
        chk("oor_lerr", 32'(if0.load_err), 1);
        if0.load_val = 4'd4;
        tick();
        chk("ld4_cnt", 32'(if0.cnt), 4);
        chk("ld4_lerr", 32'(if0.load_err), 0);
        if0.load_val = 4'd15;
        tick();
        if0.load = 1'b0;
        tick();
        chk("lerr_pulse", 32'(if0.load_err), 0);
        chk("lerr_hold", 32'(if0.cnt), 9);

        // Async reset between edges
        if0.load     = 1'b1;
        if0.load_val = 4'd6;
        tick();
        chk("ar_pre", 32'(if0.cnt), 6);
        if0.load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_imm", 32'(if0.cnt), 0);
        if0.en = 1'b1;
        tick();
        tick();
        chk("ar_hold", 32'(if0.cnt), 0);
        chk("ar_wrap", 32'(if0.wrap), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("ar_first", 32'(if0.cnt), 1);

        // Cascade: two decades from 00 to 00 over 100 clocks
        if0.clr = 1'b1;
        if1.clr = 1'b1;
        tick();
        chk("cas_clr0", 32'(if0.cnt), 0);
        chk("cas_clr1", 32'(if1.cnt), 0);
        if0.clr = 1'b0;
        if1.clr = 1'b0;
        repeat (57) tick();
        chk("cas57_lo", 32'(if0.cnt), 7);
        chk("cas57_hi", 32'(if1.cnt), 5);
        repeat (42) tick();
        chk("cas99_lo", 32'(if0.cnt), 9);
        chk("cas99_hi", 32'(if1.cnt), 9);
        chk("cas99_tc1", 32'(if1.tc), 1);
        tick();
        chk("cas100_lo", 32'(if0.cnt), 0);
        chk("cas100_hi", 32'(if1.cnt), 0);
        chk("cas100_wrap1", 32'(if1.wrap), 1);

`ifdef CONTADOR_CAPTURE_EN
        repeat (6) tick();
        chk("cap_pre", 32'(if0.cnt), 6);
        if0.cap = 1'b1;
        tick();
        if0.cap = 1'b0;
        chk("cap_val", 32'(if0.cap_val), 6);
        tick();
        chk("cap_hold", 32'(if0.cap_val), 6);
        if0.clr = 1'b1;
        tick();
        if0.clr = 1'b0;
        chk("cap_clr", 32'(if0.cap_val), 6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
